vga_fb_arbiter: RTL

VGA_FB_ARBITER -- requirements
Module: vga_fb_arbiter

---
 rtl/vga_pkg.sv | 27 ++
 rtl/vga_fb_arbiter_if.sv | 13 +
 rtl/vga_delay.sv | 25 ++
 rtl/vga_fb_arbiter.sv | 126 ++++++++++++
 4 files changed

// File: rtl/vga_pkg.sv
// Shared framebuffer geometry, bus types and clear-engine state encoding
// for the VGA framebuffer arbiter slice.
package vga_pkg;

   localparam int H_RES    = 320;
   localparam int V_RES    = 240;
   localparam int FB_WORDS = H_RES * V_RES;
   localparam int PIX_W    = 9;
   localparam int ADDR_W   = 17;

   typedef logic [PIX_W-1:0]  pixel_t;
   typedef logic [ADDR_W-1:0] addr_t;

   typedef enum logic {
      IDLE  = 1'b0,
      CLEAR = 1'b1
   } clr_state_t;

   localparam addr_t FB_LIMIT = addr_t'(FB_WORDS);
   localparam addr_t FB_LAST  = addr_t'(FB_WORDS - 1);

   // y*320 + x without a multiplier: 320 = 256 + 64.
   function automatic addr_t scan_addr(input logic [8:0] y, input logic [8:0] x);
      return (addr_t'(y) << 8) + (addr_t'(y) << 6) + addr_t'(x);
   endfunction

endpackage

// File: rtl/vga_fb_arbiter_if.sv
// Draw-port valid/ready write channel into the framebuffer arbiter.
interface vga_fb_arbiter_if;
   import vga_pkg::*;

   logic   wr_valid;
   addr_t  wr_addr;
   pixel_t wr_data;
   logic   wr_ready;

   modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
   modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);

endinterface

// File: rtl/vga_delay.sv
// N-stage, W-bit shift register used to line sync/enable up with the pixel path.
module vga_delay #(
   parameter int N = 2,
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] din,
   output logic [W-1:0] dout
);

   logic [W-1:0] pipe [N];

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < N; i++) pipe[i] <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < N; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = pipe[N-1];

endmodule

// File: rtl/vga_fb_arbiter.sv
// Single-port framebuffer arbiter: even active pixels scan out (2x doubled),
// all remaining slots go to the clear engine first, then the draw port.
module vga_fb_arbiter
   import vga_pkg::*;
(
   input  logic       clk_pix,
   input  logic       reset,
   input  logic [9:0] hcount,
   input  logic [9:0] vcount,
   input  logic       de,
   input  logic       hsync_in,
   input  logic       vsync_in,
   vga_fb_arbiter_if.slave draw,
   input  logic       clear_req,
   input  pixel_t     clear_color,
   output logic       clear_busy,
   output addr_t      mem_addr,
   output logic       mem_we,
   output pixel_t     mem_wdata,
   input  pixel_t     mem_rdata,
   output logic [2:0] rgb_r,
   output logic [2:0] rgb_g,
   output logic [2:0] rgb_b,
   output logic       hsync,
   output logic       vsync,
   output logic       de_out
);

   clr_state_t clr_state;
   addr_t      clr_cnt;
   pixel_t     clr_color;
   logic       scan_slot;
   logic       in_clear;
   logic       draw_fire;
   addr_t      scan_a;

   logic       scan_d1;
   logic       de_d1;
   pixel_t     hold;
   pixel_t     pix_sel;
   pixel_t     rgb_q;

   assign scan_slot     = de & ~hcount[0];
   assign scan_a        = scan_addr(vcount[9:1], hcount[9:1]);
   assign in_clear      = (clr_state == CLEAR);
   assign draw.wr_ready = ~reset & ~scan_slot & ~in_clear;
   assign draw_fire     = draw.wr_valid & draw.wr_ready;

   // RAM port owner: scan always wins; out-of-range draw writes complete without a write.
   always_comb begin
      mem_addr  = draw.wr_addr;
      mem_wdata = draw.wr_data;
      mem_we    = 1'b0;
      if (scan_slot) begin
         mem_addr = scan_a;
      end else if (in_clear) begin
         mem_addr  = clr_cnt;
         mem_wdata = clr_color;
         mem_we    = ~reset;
      end else begin
         mem_we = draw_fire & (draw.wr_addr < FB_LIMIT);
      end
   end

   // Clear engine: one write per free slot, stops after the last framebuffer word.
   always_ff @(posedge clk_pix) begin
      if (reset) begin
         clr_state  <= IDLE;
         clr_cnt    <= '0;
         clr_color  <= '0;
         clear_busy <= 1'b0;
      end else begin
         case (clr_state)
            IDLE: begin
               if (clear_req) begin
                  clr_state  <= CLEAR;
                  clr_color  <= clear_color;
                  clr_cnt    <= '0;
                  clear_busy <= 1'b1;
               end
            end
            CLEAR: begin
               if (!scan_slot) begin
                  if (clr_cnt == FB_LAST) begin
                     clr_state  <= IDLE;
                     clr_cnt    <= '0;
                     clear_busy <= 1'b0;
                  end else begin
                     clr_cnt <= clr_cnt + addr_t'(1);
                  end
               end
            end
            default: clr_state <= IDLE;
         endcase
      end
   end

   // Fresh read data feeds rgb directly so the doubled pair lands 2 and 3 cycles after the scan.
   assign pix_sel = scan_d1 ? mem_rdata : hold;

   always_ff @(posedge clk_pix) begin
      if (reset) begin
         scan_d1 <= 1'b0;
         de_d1   <= 1'b0;
         hold    <= '0;
         rgb_q   <= '0;
      end else begin
         scan_d1 <= scan_slot;
         de_d1   <= de;
         if (scan_d1) hold <= mem_rdata;
         rgb_q <= de_d1 ? pix_sel : '0;
      end
   end

   assign rgb_r = rgb_q[8:6];
   assign rgb_g = rgb_q[5:3];
   assign rgb_b = rgb_q[2:0];

   vga_delay #(.N(2), .W(3)) u_sync_delay (
      .clk   (clk_pix),
      .reset (reset),
      .din   ({hsync_in, vsync_in, de}),
      .dout  ({hsync, vsync, de_out})
   );

endmodule
